nibble_collector: RTL and testbench

Serial-to-parallel front end for the 4-bit reduction stage: collects single bits into 4-bit nibbles and buffers them in a 2-entry FIFO. Each nibble is presented on `nib_out` under a valid/ready handshake. It sits directly upstream of the reduction logic, which consumes `nib_out` as its 4-bit input vector. Backpressure stalls the serial side only when the FIFO is full.

---
 rtl/nibble_collector.sv | 86 ++++++++
 tb/tb_nibble_collector.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/nibble_collector.sv
// Serial-to-parallel collector: gathers single bits into 4-bit nibbles and
// buffers completed nibbles in a 2-entry FIFO with a valid/ready output side.
module nibble_collector #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       bit_ready,
  output logic [3:0] nib_out,
  output logic       nib_valid,
  input  logic       nib_ready,
  output logic [1:0] bit_cnt
);

  logic [3:0] asm_reg;
  logic [3:0] full_nib;
  logic [3:0] fifo_mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] occupancy;
  logic [1:0] bit_idx;
  logic       accept;
  logic       push;
  logic       pop;

  // Each bit is written at its final position, so the 4th bit completes the
  // nibble combinationally and can be pushed on the same edge it is accepted.
  assign bit_idx = MSB_FIRST ? (2'd3 - bit_cnt) : bit_cnt;

  always_comb begin
    full_nib          = asm_reg;
    full_nib[bit_idx] = bit_in;
  end

  // Only the 4th bit can stall, and only against registered state.
  assign bit_ready = !(occupancy == 2'd2 && bit_cnt == 2'd3);
  assign nib_valid = (occupancy != 2'd0);
  assign nib_out   = nib_valid ? fifo_mem[rd_ptr] : 4'b0000;

  assign accept = bit_valid && bit_ready && !clear;
  assign push   = accept && (bit_cnt == 2'd3);
  assign pop    = nib_valid && nib_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      asm_reg     <= 4'b0000;
      bit_cnt     <= 2'd0;
      fifo_mem[0] <= 4'b0000;
      fifo_mem[1] <= 4'b0000;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      occupancy   <= 2'd0;
    end else begin
      if (clear) begin
        asm_reg <= 4'b0000;
        bit_cnt <= 2'd0;
      end else if (accept) begin
        asm_reg <= (bit_cnt == 2'd3) ? 4'b0000 : full_nib;
        bit_cnt <= bit_cnt + 2'd1;
      end

      if (push) begin
        fifo_mem[wr_ptr] <= full_nib;
        wr_ptr           <= ~wr_ptr;
      end

      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end

      // A simultaneous push and pop leaves the occupancy unchanged.
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 2'd1;
        2'b01:   occupancy <= occupancy - 2'd1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  push_into_full : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && occupancy == 2'd2));

endmodule

// File: tb/tb_nibble_collector.sv
// Scoreboard bench for nibble_collector: LSB-first and MSB-first instances share
// stimulus; a monitor pops hand-computed expected nibbles on every handshake.
module tb_nibble_collector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       bit_in;
  logic       bit_valid;
  logic       nib_ready;

  logic       bit_ready0, nib_valid0;
  logic [3:0] nib_out0;
  logic [1:0] bit_cnt0;
  logic       bit_ready1, nib_valid1;
  logic [3:0] nib_out1;
  logic [1:0] bit_cnt1;

  int         assert_cnt = 0;
  int         fail_cnt   = 0;
  logic [3:0] exp_lsb[$];
  logic [3:0] exp_msb[$];
  logic       prev_stall = 1'b0;
  logic [3:0] prev_out   = 4'b0000;

  nibble_collector #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bit_in(bit_in),
    .bit_valid(bit_valid), .bit_ready(bit_ready0), .nib_out(nib_out0),
    .nib_valid(nib_valid0), .nib_ready(nib_ready), .bit_cnt(bit_cnt0)
  );

  nibble_collector #(.MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bit_in(bit_in),
    .bit_valid(bit_valid), .bit_ready(bit_ready1), .nib_out(nib_out1),
    .nib_valid(nib_valid1), .nib_ready(nib_ready), .bit_cnt(bit_cnt1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [3:0] actual,
                             input logic [3:0] expected);
    assert_cnt++;
    if (actual !== expected) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Inputs change at the falling edge; outputs are examined a falling edge later.
  task automatic applyStimulus(input logic rn, input logic clr, input logic bv,
                               input logic bi, input logic nr);
    rst_n     = rn;
    clear     = clr;
    bit_valid = bv;
    bit_in    = bi;
    nib_ready = nr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic sendBits(input logic [3:0] val, input int n, input logic nr);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b1, val[i], nr);
  endtask

  task automatic expectNibble(input logic [3:0] lsb, input logic [3:0] msb);
    exp_lsb.push_back(lsb);
    exp_msb.push_back(msb);
  endtask

  // Monitor: samples just after the inputs for the coming edge are settled.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && nib_valid0 && prev_stall)
        checkOutput("hold_stable", nib_out0, prev_out);
      prev_stall = rst_n && nib_valid0 && !nib_ready;
      prev_out   = nib_out0;
      if (rst_n && nib_valid0 && nib_ready) begin
        if (exp_lsb.size() == 0) begin
          assert_cnt++;
          fail_cnt++;
          $display("[TB] FAIL unexpected_pop: got %h, expected no nibble", nib_out0);
        end else begin
          checkOutput("pop_lsb", nib_out0, exp_lsb.pop_front());
          checkOutput("pop_msb", nib_out1, exp_msb.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; bit_valid = 1'b1; bit_in = 1'b1; nib_ready = 1'b0;
    @(negedge clk);

    // Reset held two cycles with bits offered
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("rst_nib_valid", 4'(nib_valid0), 4'h0);
    checkOutput("rst_bit_cnt", 4'(bit_cnt0), 4'h0);
    checkOutput("rst_nib_out", nib_out0, 4'h0);
    checkOutput("rst_bit_ready", 4'(bit_ready0), 4'h1);

    // Assembly 1,0,1,1 -> 1101 (LSB first) / 1011 (MSB first)
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("first_bit_cnt", 4'(bit_cnt0), 4'h1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("early_valid", 4'(nib_valid0), 4'h0);
    expectNibble(4'b1101, 4'b1011);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("latency_valid", 4'(nib_valid0), 4'h1);
    checkOutput("wrap_bit_cnt", 4'(bit_cnt0), 4'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("one_cycle_valid", 4'(nib_valid0), 4'h0);
    checkOutput("empty_nib_out", nib_out0, 4'h0);

    // Backpressure: A, 5, then three bits of a third nibble
    expectNibble(4'hA, 4'h5);
    sendBits(4'hA, 4, 1'b0);
    expectNibble(4'h5, 4'hA);
    sendBits(4'h5, 4, 1'b0);
    sendBits(4'b1011, 3, 1'b0);
    checkOutput("full_bit_cnt", 4'(bit_cnt0), 4'h3);
    checkOutput("full_bit_ready", 4'(bit_ready0), 4'h0);
    checkOutput("full_head", nib_out0, 4'hA);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("stall_bit_cnt", 4'(bit_cnt0), 4'h3);
    checkOutput("stall_bit_ready", 4'(bit_ready0), 4'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("no_ready_through", 4'(bit_cnt0), 4'h3);
    checkOutput("ready_after_pop", 4'(bit_ready0), 4'h1);
    checkOutput("head_update", nib_out0, 4'h5);
    expectNibble(4'hB, 4'hD);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("twelfth_bit_cnt", 4'(bit_cnt0), 4'h0);
    checkOutput("twelfth_head", nib_out0, 4'h5);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("drain_valid", 4'(nib_valid0), 4'h0);

    // Simultaneous push and pop at occupancy 1
    expectNibble(4'h3, 4'hC);
    sendBits(4'h3, 4, 1'b0);
    sendBits(4'hC, 3, 1'b0);
    expectNibble(4'hC, 4'h3);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("pushpop_head", nib_out0, 4'hC);
    checkOutput("pushpop_head_msb", nib_out1, 4'h3);
    checkOutput("pushpop_valid", 4'(nib_valid0), 4'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("pushpop_occ1", 4'(nib_valid0), 4'h0);

    // clear mid-nibble with a buffered nibble present
    expectNibble(4'h9, 4'h9);
    sendBits(4'h9, 4, 1'b0);
    sendBits(4'b0011, 2, 1'b0);
    checkOutput("pre_clear_cnt", 4'(bit_cnt0), 4'h2);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("clear_bit_cnt", 4'(bit_cnt0), 4'h0);
    checkOutput("clear_fifo_kept", nib_out0, 4'h9);
    expectNibble(4'h2, 4'h4);
    sendBits(4'h2, 4, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("clear_drain", 4'(nib_valid0), 4'h0);

    // Reset mid-operation: occupancy 2, two partial bits
    sendBits(4'h7, 4, 1'b0);
    sendBits(4'hE, 4, 1'b0);
    sendBits(4'h3, 2, 1'b0);
    checkOutput("mid_bit_cnt", 4'(bit_cnt0), 4'h2);
    checkOutput("mid_valid", 4'(nib_valid0), 4'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("mid_rst_valid", 4'(nib_valid0), 4'h0);
    checkOutput("mid_rst_cnt", 4'(bit_cnt0), 4'h0);
    checkOutput("mid_rst_out", nib_out0, 4'h0);
    checkOutput("mid_rst_ready", 4'(bit_ready0), 4'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("no_stale", 4'(nib_valid0), 4'h0);
    expectNibble(4'h6, 4'h6);
    sendBits(4'h6, 4, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("final_valid", 4'(nib_valid0), 4'h0);

    assert_cnt++;
    if (exp_lsb.size() != 0) begin
      fail_cnt++;
      $display("[TB] FAIL scoreboard_empty: got %0d pending, expected 0", exp_lsb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
